// File: rtl/aes_stream_if.sv
// aes_stream_if: 32-bit word-serial input and output streams around the AES controller
interface aes_stream_if;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic        in_is_key;
  logic        in_mode;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic        out_last;
  modport slave (
    input  in_valid, in_data, in_is_key, in_mode, out_ready,
    output in_ready, out_valid, out_data, out_last
  );
  modport master (
    output in_valid, in_data, in_is_key, in_mode, out_ready,
    input  in_ready, out_valid, out_data, out_last
  );
endinterface

// File: rtl/aes_stream_ctrl.sv
// aes_stream_ctrl: assembles key/block words for the AES wrapper and serialises its result
module aes_stream_ctrl (
  input  logic           clk,
  input  logic           rst_n,
  aes_stream_if.slave    s,
  output logic [127:0]   aes_in_data,
  output logic [127:0]   aes_key,
  output logic           aes_flag,
  input  logic [127:0]   aes_data_out,
  output logic           key_err
);
  localparam logic [1:0] LOAD    = 2'd0;
  localparam logic [1:0] ISSUE   = 2'd1;
  localparam logic [1:0] CAPTURE = 2'd2;
  localparam logic [1:0] SEND    = 2'd3;
  logic [1:0]   state_q, state_d;
  logic [1:0]   kcnt_q, kcnt_d, dcnt_q, dcnt_d, ocnt_q, ocnt_d;
  logic [127:0] key_q, key_d, blk_q, blk_d, res_q, res_d;
  logic         mode_q, mode_d, key_err_q, key_err_d;
  always_comb begin
    state_d   = state_q;
    kcnt_d    = kcnt_q;
    dcnt_d    = dcnt_q;
    ocnt_d    = ocnt_q;
    key_d     = key_q;
    blk_d     = blk_q;
    res_d     = res_q;
    mode_d    = mode_q;
    key_err_d = key_err_q;
    case (state_q)
      LOAD: if (s.in_valid) begin
        if (s.in_is_key) begin
          key_d  = {key_q[95:0], s.in_data};
          kcnt_d = kcnt_q + 2'd1;
        end else begin
          blk_d  = {blk_q[95:0], s.in_data};
          dcnt_d = dcnt_q + 2'd1;
          if (dcnt_q == 2'd3) begin
            mode_d    = s.in_mode;
            key_err_d = key_err_q | (kcnt_q != 2'd0);
            state_d   = ISSUE;
          end
        end
      end
      ISSUE: state_d = CAPTURE;
      CAPTURE: begin
        res_d   = aes_data_out;
        ocnt_d  = 2'd0;
        state_d = SEND;
      end
      default: if (s.out_ready) begin
        ocnt_d  = ocnt_q + 2'd1;
        state_d = (ocnt_q == 2'd3) ? LOAD : SEND;
      end
    endcase
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= LOAD;
      kcnt_q    <= '0;
      dcnt_q    <= '0;
      ocnt_q    <= '0;
      key_q     <= '0;
      blk_q     <= '0;
      res_q     <= '0;
      mode_q    <= 1'b0;
      key_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      kcnt_q    <= kcnt_d;
      dcnt_q    <= dcnt_d;
      ocnt_q    <= ocnt_d;
      key_q     <= key_d;
      blk_q     <= blk_d;
      res_q     <= res_d;
      mode_q    <= mode_d;
      key_err_q <= key_err_d;
    end
  end
  // ~ocnt_q selects word 3-ocnt, so word 0 is the most-significant one
  assign s.in_ready   = state_q == LOAD;
  assign s.out_valid  = state_q == SEND;
  assign s.out_data   = res_q[{~ocnt_q, 5'd0} +: 32];
  assign s.out_last   = (state_q == SEND) && (ocnt_q == 2'd3);
  assign aes_in_data  = blk_q;
  assign aes_key      = key_q;
  assign aes_flag     = mode_q;
  assign key_err      = key_err_q;
endmodule
